// File: rtl/fifo_serial_transmitter_pkg.sv
// rtl/fifo_serial_transmitter_pkg.sv - shared types, defaults and helpers for the serial drain stage
package fifo_serial_transmitter_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } tx_state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/fifo_serial_transmitter_baud_tick_generator.sv
// rtl/fifo_serial_transmitter_baud_tick_generator.sv - free-running bit-period counter with one-cycle tick
module baud_tick_generator
  import fifo_serial_transmitter_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic tick_o
);

  localparam int CNT_W = clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = (count_q == LAST_COUNT) ? '0 : count_q + CNT_W'(1);
    end
  end

  assign tick_o = enable_i && !clear_i && (count_q == LAST_COUNT);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fifo_serial_transmitter.sv
// rtl/fifo_serial_transmitter.sv - pops FIFO words and shifts them out as start/data/parity/stop frames
module fifo_serial_transmitter
  import fifo_serial_transmitter_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int CLKS_PER_BIT = 4,
  parameter bit PARITY_EN    = 1'b1
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic                  Fifo_Empty_In,
  input  logic [DATA_WIDTH-1:0] Fifo_Data_In,
  output logic                  Fifo_Read_Enable_Out,
  input  logic                  Tx_Enable_In,
  output logic                  Serial_Out,
  output logic                  Busy_Out,
  output logic                  Frame_Done_Out
);

  localparam int BIT_W = clog2(DATA_WIDTH + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  parity_q, parity_d;
  logic                  baud_clear, baud_enable, bit_tick;

  baud_tick_generator #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk_i   (Clk_In),
    .rst_n_i (Reset_In),
    .clear_i (baud_clear),
    .enable_i(baud_enable),
    .tick_o  (bit_tick)
  );

  always_ff @(posedge Clk_In or negedge Reset_In) begin
    if (!Reset_In) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      parity_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      parity_q  <= parity_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    parity_d  = parity_q;
    unique case (state_q)
      IDLE:  if (Tx_Enable_In && !Fifo_Empty_In) state_d = FETCH;
      FETCH: state_d = LOAD;
      LOAD: begin
        // Read data arrives the cycle after the pop issued in FETCH.
        shift_d   = Fifo_Data_In;
        parity_d  = ^Fifo_Data_In;
        bit_cnt_d = '0;
        state_d   = START;
      end
      START: if (bit_tick) state_d = DATA;
      DATA: begin
        if (bit_tick) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          if (bit_cnt_q == LAST_BIT) begin
            if (PARITY_EN) state_d = PARITY;
            else           state_d = STOP;
          end
        end
      end
      PARITY: if (bit_tick) state_d = STOP;
      STOP:   if (bit_tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    Busy_Out             = (state_q != IDLE);
    Fifo_Read_Enable_Out = (state_q == FETCH);
    Frame_Done_Out       = (state_q == STOP) && bit_tick;
    baud_clear           = (state_q == LOAD);
    baud_enable          = state_q inside {START, DATA, PARITY, STOP};
    Serial_Out           = 1'b1;
    case (state_q)
      START:   Serial_Out = 1'b0;
      DATA:    Serial_Out = shift_q[0];
      PARITY:  Serial_Out = parity_q;
      default: Serial_Out = 1'b1;
    endcase
  end

endmodule
